// File: rtl/ntt_roundtrip_checker.sv
// ntt_roundtrip_checker: in-order timestamped scoreboard for NTT->iNTT round trips.
// Define NTT_CHK_FIRST_ERR_EN to add first-mismatch capture outputs.
module ntt_roundtrip_checker #(
  parameter int LANES   = 8,
  parameter int W       = 12,
  parameter int DEPTH   = 32,
  parameter int MAX_LAT = 64,
  parameter int CNT_W   = 32
) (
  input  logic                        clk,
  input  logic                        r,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic [LANES*W-1:0]          in_coeffs,
  input  logic                        out_valid,
  input  logic [LANES*W-1:0]          out_coeffs,
  output logic                        mismatch,
  output logic [LANES-1:0]            lane_err,
  output logic [CNT_W-1:0]            err_count,
  output logic [CNT_W-1:0]            vec_count,
  output logic [$clog2(MAX_LAT)+1:0]  last_lat,
  output logic [$clog2(DEPTH):0]      occupancy,
  output logic                        overflow,
  output logic                        underflow,
  output logic                        timeout,
  output logic                        pass
`ifdef NTT_CHK_FIRST_ERR_EN
  ,
  output logic [CNT_W-1:0]            first_err_idx,
  output logic [LANES*W-1:0]          first_err_exp,
  output logic [LANES*W-1:0]          first_err_got
`endif
);

  localparam int TS_W = $clog2(MAX_LAT) + 2;
  localparam int PW   = $clog2(DEPTH);
  localparam int OW   = PW + 1;
  localparam int VW   = LANES * W;

  logic [VW-1:0]   mem_d  [DEPTH];
  logic [TS_W-1:0] mem_ts [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [TS_W-1:0] ts;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [VW-1:0]   head_d;
  logic [TS_W-1:0] age;
  logic [LANES-1:0] diff;

  assign full   = occupancy == OW'(DEPTH);
  assign empty  = occupancy == '0;
  assign push   = in_valid & ~full;
  assign pop    = out_valid & ~empty;
  assign head_d = mem_d[rd_ptr];
  assign age    = ts - mem_ts[rd_ptr];

  assign pass = (vec_count != '0) && (err_count == '0)
             && !overflow && !underflow && !timeout
             && empty;

  // Lane-by-lane compare of the DUT output against the queue head
  always_comb begin
    diff = '0;
    for (int i = 0; i < LANES; i++)
      diff[i] = head_d[i*W +: W] != out_coeffs[i*W +: W];
  end

  // Queue storage: payload plus push timestamp, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_d[wr_ptr]  <= in_coeffs;
      mem_ts[wr_ptr] <= ts;
    end
  end

  // Pointers, timestamp, registered compare results and sticky flags
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ts        <= '0;
      occupancy <= '0;
      mismatch  <= 1'b0;
      lane_err  <= '0;
      err_count <= '0;
      vec_count <= '0;
      last_lat  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      timeout   <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ts        <= '0;
      occupancy <= '0;
      mismatch  <= 1'b0;
      lane_err  <= '0;
      err_count <= '0;
      vec_count <= '0;
      last_lat  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
      mismatch <= pop && (diff != '0);
      if (pop) begin
        lane_err <= diff;
        last_lat <= age;
        if (vec_count != '1)
          vec_count <= vec_count + CNT_W'(1);
        if ((diff != '0) && (err_count != '1))
          err_count <= err_count + CNT_W'(1);
      end
      if (in_valid && full)  overflow  <= 1'b1;
      if (out_valid && empty) underflow <= 1'b1;
      if (!empty && (age > TS_W'(MAX_LAT)))
        timeout <= 1'b1;
    end
  end

`ifdef NTT_CHK_FIRST_ERR_EN
  // Capture index and vectors of the first failing compare only
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (clear) begin
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (pop && (diff != '0) && (err_count == '0)) begin
      first_err_idx <= vec_count;
      first_err_exp <= head_d;
      first_err_got <= out_coeffs;
    end
  end
`endif

endmodule

// File: doc/ntt_roundtrip_checker.md
Name: ntt_roundtrip_checker

Overview:
- Synthesizable, parametrised self-checking scoreboard for NTT→iNTT round-trip datapaths.
- Queues every input coefficient vector with a timestamp, then compares each output vector against the oldest queued entry, in order.
- Reports mismatches, per-lane error masks, measured latency, overflow, underflow and timeout.
- Replaces fixed-latency delay-buffer comparison in benches and is usable on-chip as a BIST monitor.

Parameters:
- LANES, 8, coefficients per vector.
- W, 12, coefficient width in bits.
- DEPTH, 32, maximum outstanding vectors; power of two, ≥2.
- MAX_LAT, 64, cycles an entry may wait before timeout is raised.
- CNT_W, 32, width of the error and vector counters.

Ports:
- clk  in  1  rising-edge clock.
- r  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of counters, flags and queue.
- in_valid  in  1  stimulus vector presented to the DUT this cycle.
- in_coeffs  in  [W-1:0] x LANES  stimulus vector.
- out_valid  in  1  DUT output vector valid.
- out_coeffs  in  [W-1:0] x LANES  DUT output vector.
- mismatch  out  1  one-cycle pulse: last compare failed.
- lane_err  out  LANES  per-lane failure mask of the last compare.
- err_count  out  CNT_W  mismatching vectors, saturating.
- vec_count  out  CNT_W  compared vectors, saturating.
- last_lat  out  $clog2(MAX_LAT)+2  latency of the last compared vector.
- occupancy  out  $clog2(DEPTH)+1  queued entries.
- overflow  out  1  sticky: push while full.
- underflow  out  1  sticky: out_valid while empty.
- timeout  out  1  sticky: head entry age > MAX_LAT.
- pass  out  1  vec_count>0, err_count==0, all sticky flags low, occupancy==0.

Behaviour:
- Reset (r=0, async): all outputs 0; queue empty; timestamp counter 0. `clear`=1 produces the same state synchronously and has priority over push and pop in that cycle.
- Timestamp: free-running counter TS_W=$clog2(MAX_LAT)+2 bits, wraps naturally. Age = (now − stamp) mod 2^TS_W, which is unambiguous because timeout fires before wrap.
- Push (in_valid=1, not full): store {in_coeffs, timestamp}; write pointer increments mod DEPTH.
- Push while full: data dropped, overflow set. A simultaneous pop that cycle does not make room: fullness is evaluated before pop.
- Pop (out_valid=1, not empty): compare out_coeffs against the head entry lane by lane; read pointer increments.
- Compare registration: results are registered and visible exactly one cycle after the out_valid edge.
  - lane_err[i]=1 iff lane i differs.
  - mismatch=|lane_err.
  - vec_count+1; err_count+1 if mismatch.
  - last_lat=age of the head entry (cycles from push edge to pop edge).
- Counters saturate at all-ones.
- out_valid while empty: underflow set, no compare, counts unchanged, mismatch stays 0. This applies even if in_valid is high the same cycle; there is no bypass.
- Simultaneous push and pop with 0<occupancy<DEPTH: both occur; occupancy unchanged.
- Timeout: each cycle with occupancy>0, if head age > MAX_LAT then timeout is set. The entry is not discarded.
- lane_err holds its value until the next compare; mismatch is a pulse.
- Reset asserted mid-stream: queue and all statistics are lost immediately; no partial compare is reported.
- Storage: flop or inferred RAM, with no read latency visible beyond the one-cycle result register.

Optional Feature:
- Macro: NTT_CHK_FIRST_ERR_EN.
- When defined, three additional outputs are present:
  - first_err_idx [CNT_W-1:0]: vec_count value of the first mismatching compare, 0-based.
  - first_err_exp and first_err_got [W-1:0] x LANES: expected and observed vectors of that compare.
  - All three are captured once, held until reset or clear, and reset to 0.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Push 20 vectors (lane j of vector n = n*8+j), return identical vectors 17 cycles later → vec_count=20, err_count=0, last_lat=17, pass=1 after drain.
- Same stream with vector 5 lane 3 XOR 1 → mismatch pulse once, lane_err=8'b0000_1000, err_count=1; first_err_idx=5 with the feature enabled.
- out_valid with empty queue → underflow=1, vec_count=0, pass=0.
- 33 consecutive pushes with DEPTH=32 and no pops → overflow=1, occupancy=32.
- One push, no output for 65 cycles with MAX_LAT=64 → timeout=1 on the cycle age reaches 65; a later matching pop still gives vec_count=1 and last_lat≥65.
- Mid-stream r=0 pulse with 4 entries queued → all outputs 0 asynchronously; after release, a fresh 3-vector round-trip gives vec_count=3, pass=1.
